// File: rtl/veririsc_pkg.sv
// Shared types and constants for the VeriRISC accumulator core.
// Optional retired-instruction counter: VERIRISC_RETIRE_CNT_EN.
package veririsc_pkg;

    // Opcode occupies the top OP_W bits of the instruction word.
    localparam int unsigned OP_W = 3;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    function automatic int unsigned op_lsb(input int unsigned w);
        return w - OP_W;
    endfunction

    function automatic logic is_mem_op(input opcode_e op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) ||
               (op == OP_LDA) || (op == OP_STO);
    endfunction

endpackage

// File: rtl/veririsc_alu.sv
// Combinational accumulator ALU; passes AC through for non-arithmetic opcodes.
module veririsc_alu
    import veririsc_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [OP_W-1:0] i_op,
    input  logic [W-1:0]    i_ac,
    input  logic [W-1:0]    i_data,
    output logic [W-1:0]    o_result,
    output logic            o_a_is_zero
);

    always_comb begin
        o_result = i_ac;
        case (opcode_e'(i_op))
            OP_ADD:  o_result = i_ac + i_data;
            OP_AND:  o_result = i_ac & i_data;
            OP_XOR:  o_result = i_ac ^ i_data;
            OP_LDA:  o_result = i_data;
            default: o_result = i_ac;
        endcase
    end

    assign o_a_is_zero = (i_ac == '0);

endmodule

// File: rtl/veririsc_core.sv
// VeriRISC accumulator CPU with FSM sequencing and an external wait-state memory handshake.
// Optional retired-instruction counter port o_retired: VERIRISC_RETIRE_CNT_EN.
module veririsc_core
    import veririsc_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned AW = 5
) (
    input  logic          i_top_clk,
    input  logic          i_top_rst_n,
    input  logic          i_top_run,
    output logic          o_top_halt,
    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [W-1:0]  o_mem_wdata,
    input  logic [W-1:0]  i_mem_rdata,
`ifdef VERIRISC_RETIRE_CNT_EN
    input  logic          i_mem_ack,
    output logic [15:0]   o_retired
`else
    input  logic          i_mem_ack
`endif
);

    state_e          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [W-1:0]    ir_q, ir_d;
    logic [W-1:0]    ac_q, ac_d;

    opcode_e         op;
    logic [AW-1:0]   ir_addr;
    logic            mem_op;
    logic            exec_done;
    logic [W-1:0]    alu_result;
    logic            ac_is_zero;
    logic            unused_ir_bits;

    assign op             = opcode_e'(ir_q[W-1 -: OP_W]);
    assign ir_addr        = ir_q[AW-1:0];
    assign mem_op         = is_mem_op(op);
    assign unused_ir_bits = ^ir_q;

    veririsc_alu #(.W(W)) u_alu (
        .i_op        (ir_q[W-1 -: OP_W]),
        .i_ac        (ac_q),
        .i_data      (i_mem_rdata),
        .o_result    (alu_result),
        .o_a_is_zero (ac_is_zero)
    );

    // Memory ops finish on ack; all other opcodes finish in their single EXEC cycle.
    assign exec_done = (state_q == ST_EXEC) && (!mem_op || i_mem_ack);

    always_ff @(posedge i_top_clk or negedge i_top_rst_n) begin
        if (!i_top_rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= '0;
            ir_q    <= '0;
            ac_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ac_q    <= ac_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ac_d    = ac_q;
        case (state_q)
            ST_BOOT:   state_d = ST_FETCH;
            ST_FETCH: begin
                if (i_mem_ack) begin
                    ir_d    = i_mem_rdata;
                    pc_d    = pc_q + AW'(1);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                case (op)
                    OP_HLT: state_d = ST_HALT;
                    OP_SKZ: begin
                        if (ac_is_zero) pc_d = pc_q + AW'(1);
                        state_d = ST_FETCH;
                    end
                    OP_JMP: begin
                        pc_d    = ir_addr;
                        state_d = ST_FETCH;
                    end
                    OP_STO: begin
                        if (i_mem_ack) state_d = ST_FETCH;
                    end
                    default: begin
                        if (i_mem_ack) begin
                            ac_d    = alu_result;
                            state_d = ST_FETCH;
                        end
                    end
                endcase
            end
            ST_HALT: begin
                if (i_top_run) state_d = ST_FETCH;
            end
            default:   state_d = ST_BOOT;
        endcase
    end

    // Bus outputs decode only from state/PC/IR/AC so ack and rdata never reach them.
    always_comb begin
        o_mem_req   = (state_q == ST_FETCH) || ((state_q == ST_EXEC) && mem_op);
        o_mem_we    = (state_q == ST_EXEC) && (op == OP_STO);
        o_mem_addr  = '0;
        if (state_q == ST_FETCH)
            o_mem_addr = pc_q;
        else if ((state_q == ST_EXEC) && mem_op)
            o_mem_addr = ir_addr;
        o_mem_wdata = o_mem_we ? ac_q : '0;
        o_top_halt  = (state_q == ST_HALT);
    end

`ifdef VERIRISC_RETIRE_CNT_EN
    logic [15:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (exec_done) retired_d = retired_q + 16'd1;
    end

    always_ff @(posedge i_top_clk or negedge i_top_rst_n) begin
        if (!i_top_rst_n) retired_q <= '0;
        else              retired_q <= retired_d;
    end

    assign o_retired = retired_q;
`else
    logic unused_exec_done;
    assign unused_exec_done = exec_done;
`endif

endmodule

// File: doc/veririsc_core.md
# veririsc_core

Parametrised accumulator CPU core: the successor of the fixed 8-bit, 5-bit-address VeriRISC top level. It replaces the free-running 8-phase counter and internal memory with a state machine and an external single-port memory handshake that tolerates wait states. It adds a restart input to resume from HALT, and a compile-time retired-instruction counter. The core sits between the platform memory/bus model and the test harness, as the new CPU top.

## Interface
- W, default 8: data and instruction word width; W >= AW+3 is required.
- AW, default 5: address width; PC, IR address field and memory address.
- i_top_clk, input, 1: sole clock, rising edge.
- i_top_rst_n, input, 1: asynchronous, active-low reset.
- i_top_run, input, 1: in HALT, high for one cycle resumes execution; ignored otherwise.
- o_top_halt, output, 1: high while in HALT state.
- o_mem_req, output, 1: memory request; held until acknowledged.
- o_mem_we, output, 1: 1 = write, 0 = read; valid with o_mem_req.
- o_mem_addr, output, AW: memory address; valid with o_mem_req.
- o_mem_wdata, output, W: write data (accumulator); valid when o_mem_req and o_mem_we are high.
- i_mem_rdata, input, W: read data; sampled on the edge where i_mem_ack is high.
- i_mem_ack, input, 1: completes the pending request; may rise in the same cycle as o_mem_req (zero wait).
- o_retired, output, 16: retired-instruction count; present only with VERIRISC_RETIRE_CNT_EN.

## Operation
- Instruction word: opcode = bits [W-1:W-3]; operand address = bits [AW-1:0]; bits between them are ignored.
- Opcodes: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.
- States:
  - BOOT: reset state, no request. Next: FETCH.
  - FETCH: read at PC. Wait for ack; on ack, IR <= rdata and PC <= PC+1. Next: DECODE.
  - DECODE: one cycle, no request. Next: EXEC.
  - EXEC: executes the opcode (see below).
  - HALT: no request. Next: FETCH on i_top_run, otherwise stays in HALT.
- EXEC by opcode:
  - ADD, AND, XOR, LDA: read at the IR address and wait for ack. On ack, AC <= AC+data, AC&data, AC^data or data respectively. Next: FETCH.
  - STO: write AC to the IR address and wait for ack; AC is unchanged. Next: FETCH.
  - JMP: PC <= IR address; no memory access. Next: FETCH.
  - SKZ: if AC == 0, PC <= PC+1; no memory access. Next: FETCH.
  - HLT: no memory access. Next: HALT.
- Arithmetic:
  - ADD is modulo 2^W and discards the carry.
  - PC increments modulo 2^AW, so PC wraps from 2^AW-1 to 0. This applies to both the fetch increment and the SKZ skip.
- Zero flag: combinational (AC == 0), evaluated in the EXEC cycle of SKZ.
- Handshake:
  - o_mem_addr, o_mem_we and o_mem_wdata stay stable while o_mem_req is high and ack is low.
  - o_mem_req drops in the cycle after ack unless a new request follows.
  - i_mem_ack while o_mem_req is low is ignored.
- After resume from HALT, execution continues at the already-incremented PC.

## Timing
- Reset values: o_mem_req 0, o_mem_we 0, o_mem_addr 0, o_mem_wdata 0, o_top_halt 0, PC 0, AC 0, IR 0, state BOOT, o_retired 0.
- Reset release: BOOT for 1 cycle; o_mem_req rises in the 2nd cycle after release, addressing 0.
- Latency with zero-wait memory: every instruction takes 3 cycles (FETCH, DECODE, EXEC).
- Each memory wait cycle adds 1 cycle to FETCH and to the EXEC of memory opcodes.
- o_top_halt rises in the cycle after HLT's EXEC. The first fetch after i_top_run is in the cycle following the i_top_run cycle.
- Reset asserted mid-transaction: all outputs go to their reset values immediately, asynchronously. A pending request is abandoned and no state update occurs.
- o_mem_req, o_mem_we, o_mem_addr and o_top_halt are decoded from the state register and PC/IR. They have no combinational path from i_mem_ack or i_mem_rdata.

## Configuration
- VERIRISC_RETIRE_CNT_EN defined:
  - o_retired is present.
  - It increments by 1 on the final cycle of each instruction's EXEC, including HLT.
  - It wraps at 2^16.
- VERIRISC_RETIRE_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- veririsc_pkg holds:
  - the opcode enum (HLT..JMP, 3 bits);
  - the state enum (BOOT, FETCH, DECODE, EXEC, HALT);
  - the opcode field position constants.
- One combinational sub-module, veririsc_alu, parametrised by W. Inputs: opcode, AC, memory data. Outputs: result and a_is_zero.
- PC, IR, AC and the FSM live in veririsc_core.

## Test plan
- Reset and boot: assert i_top_rst_n low, then release. Require all outputs at 0 and o_mem_req high with o_mem_addr 0 in the 2nd cycle.
- Arithmetic, zero-wait memory, W=8: program LDA 0x1E, ADD 0x1F, STO 0x1D, HLT, with mem[0x1E]=0xF0 and mem[0x1F]=0x20. Require mem[0x1D]=0x10, o_top_halt high 12 cycles after the first fetch, and o_retired=4.
- Skip and jump: with AC=0, SKZ then JMP 0x00. Require the JMP to be skipped and the fetch to occur at address 3. With AC=1, require the JMP to be taken and the next fetch at 0x00.
- Wait states: delay ack by 3 cycles on every access. Require the request address, we and data to stay stable throughout, each instruction to take 3 cycles per memory access longer, and the same final memory contents as with zero wait.
- PC wrap and resume, AW=5: HLT at 0x1F, then pulse i_top_run. Require the next fetch at 0x00.
- Reset mid-write: assert reset while STO is waiting for ack. Require o_mem_req to drop immediately and the core to restart at BOOT with PC=0 and AC=0.
